// File: rtl/fsm1_arb_pkg.sv
// Shared types and constants for the fsm1 round-robin arbiter/sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   MAX_NREQ      largest supported requester count
//   arb_state_e   sequencer state encoding; A_XXX marks an unreachable encoding
//   ptr_width()   index width for a given requester count (at least 1 bit)
package fsm1_arb_pkg;

  localparam int MAX_NREQ = 16;

  // A_XXX is never entered by legal operation. Driving it from the default
  // branch poisons state and outputs so an illegal encoding is obvious in
  // simulation instead of being silently recovered.
  typedef enum logic [1:0] {
    A_IDLE = 2'b00,
    A_GO   = 2'b01,
    A_WAIT = 2'b10,
    A_XXX  = 2'bxx
  } arb_state_e;

  // Index width for a requester vector. A single requester still needs a
  // one-bit pointer so the ports and registers have a legal width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsm1_rr_pick.sv
// Round-robin winner selection: first set request scanning ptr, ptr+1, ... mod NREQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   req      in   NREQ  level request vector
//   ptr      in   PW    highest-priority index for this scan (must be < NREQ)
//   win_oh   out  NREQ  one-hot winner, zero when no request is set
//   win_idx  out  PW    binary index of the winner, zero when no request is set
//   win_vld  out  1     at least one request was set
module fsm1_rr_pick
  import fsm1_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            win_vld
);

  // Walk the requesters in priority order starting at ptr. The index wraps
  // by a single subtraction because ptr is always below NREQ, so the sum
  // never reaches 2*NREQ and no divider is needed.
  always_comb begin : pick
    int idx;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!win_vld && req[idx]) begin
        win_vld     = 1'b1;
        win_idx     = PW'(idx);
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm1_arb.sv
// Round-robin arbiter sharing one go/ds read engine among NREQ requesters.
// Latency: req in IDLE cycle N -> gnt+go in N+1; ds cycle k -> next go earliest k+2 (k+1 with lock).
// Backpressure: requests wait at level until granted; the engine paces transfers via ds.
//
// Ports:
//   clk        in   1     clock, all state on posedge
//   rst_n      in   1     synchronous active-low reset
//   req        in   NREQ  level request per requester
//   gnt        out  NREQ  one-hot grant, held for the whole transfer
//   done       out  NREQ  one-cycle completion pulse to the granted requester (same cycle as ds)
//   go         out  1     start strobe to the read engine
//   rd         in   1     engine read-phase indicator, counted while waiting
//   ds         in   1     engine done strobe
//   busy       out  1     high in any state other than IDLE
//   wcnt       out  CNTW  rd-cycle count of the last completed transfer (saturating)
//   proto_err  out  1     sticky: ds seen while no transfer was waiting for it
//   lock       in   NREQ  present only when FSM1_ARB_LOCK_EN is defined: winner keeps the
//                         grant for a back-to-back transfer
//
// Build option: FSM1_ARB_LOCK_EN adds the lock port and the back-to-back path.
module fsm1_arb
  import fsm1_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            go,
  input  logic            rd,
  input  logic            ds,
  output logic            busy,
  output logic [CNTW-1:0] wcnt,
  output logic            proto_err
`ifdef FSM1_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0] lock
`endif
);

  localparam int              PW      = ptr_width(NREQ);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0]   IDX_TOP = PW'(NREQ - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e      state_q,  state_nxt;
  logic [NREQ-1:0] gnt_q,    gnt_nxt;
  logic [PW-1:0]   ptr_q,    ptr_nxt;
  logic [PW-1:0]   win_q,    win_nxt;
  logic [CNTW-1:0] cnt_q,    cnt_nxt;
  logic [CNTW-1:0] wcnt_q,   wcnt_nxt;
  logic            err_q,    err_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;

  fsm1_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // rd-cycle count including the current cycle. Used both for the running
  // count and for the report on ds, so an rd coinciding with ds is counted.
  logic [CNTW-1:0] cnt_inc;
  assign cnt_inc = (rd && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  // Priority moves to the requester just after the winner. With NREQ=1
  // IDX_TOP is 0, so the pointer stays 0.
  logic [PW-1:0] ptr_after_win;
  assign ptr_after_win = (win_q >= IDX_TOP) ? '0 : win_q + 1'b1;

  // Back-to-back hold: only the current winner's lock counts, and only
  // while it is still requesting.
  logic keep_gnt;
`ifdef FSM1_ARB_LOCK_EN
  assign keep_gnt = lock[win_q] & req[win_q];
`else
  assign keep_gnt = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    ptr_nxt   = ptr_q;
    win_nxt   = win_q;
    cnt_nxt   = cnt_q;
    wcnt_nxt  = wcnt_q;
    err_nxt   = err_q;
    go        = 1'b0;
    busy      = 1'b1;
    done      = '0;

    case (state_q)
      A_IDLE: begin
        busy    = 1'b0;
        gnt_nxt = '0;
        if (ds) begin
          err_nxt = 1'b1;
        end
        if (pick_vld) begin
          gnt_nxt   = pick_oh;
          win_nxt   = pick_idx;
          cnt_nxt   = '0;
          state_nxt = A_GO;
        end
      end

      A_GO: begin
        go = 1'b1;
        // The engine has not been started yet, so a ds here cannot belong
        // to this transfer.
        if (ds) begin
          err_nxt = 1'b1;
        end
        state_nxt = A_WAIT;
      end

      A_WAIT: begin
        cnt_nxt = cnt_inc;
        if (ds) begin
          // A reset in the ds cycle aborts the transfer, so suppress the
          // completion pulse along with it.
          done     = rst_n ? gnt_q : '0;
          wcnt_nxt = cnt_inc;
          if (keep_gnt) begin
            cnt_nxt   = '0;
            state_nxt = A_GO;
          end else begin
            gnt_nxt   = '0;
            ptr_nxt   = ptr_after_win;
            state_nxt = A_IDLE;
          end
        end
      end

      default: begin
        state_nxt = A_XXX;
        gnt_nxt   = 'x;
        ptr_nxt   = 'x;
        win_nxt   = 'x;
        cnt_nxt   = 'x;
        wcnt_nxt  = 'x;
        err_nxt   = 1'bx;
        go        = 1'bx;
        busy      = 1'bx;
        done      = 'x;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= A_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      ptr_q   <= ptr_nxt;
      win_q   <= win_nxt;
      cnt_q   <= cnt_nxt;
      wcnt_q  <= wcnt_nxt;
      err_q   <= err_nxt;
    end
  end

  assign gnt       = gnt_q;
  assign wcnt      = wcnt_q;
  assign proto_err = err_q;

endmodule
